// File: rtl/pkt_merge_arb_pkg.sv
// pkt_merge_arb_pkg
//   Shared definitions for the two-port packet merger:
//   - word width and the word-type tag values carried in bits [133:132]
//   - arbiter FSM state encoding
//   - default values for the FIFO address width and admission threshold
//   - a helper that extracts the tag from a stream word
package pkt_merge_arb_pkg;

  localparam int unsigned WORD_W            = 134;
  localparam int unsigned DEF_FIFO_AW       = 8;
  localparam int unsigned DEF_MAX_PKT_WORDS = 128;

  // Word-type tags in the top two bits of every stream word.
  localparam logic [1:0] TAG_FIRST = 2'b01;
  localparam logic [1:0] TAG_MID   = 2'b11;
  localparam logic [1:0] TAG_LAST  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_SEND = 2'd2
  } arb_state_e;

  function automatic logic [1:0] word_tag(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: 2];
  endfunction

endpackage

// File: rtl/pkt_merge_arb_sync_fifo.sv
// pkt_sync_fifo
//   Per-port packet store: admission filter, 2^FIFO_AW x 134 data RAM with a
//   registered read port, read/write pointers, free-word count, a count of
//   complete packets held (EOP counter) and a saturating drop counter.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   i_wr_data      incoming stream word (tag in [133:132])
//   i_wr           incoming word valid (no backpressure)
//   i_rd           pop the head word; data appears on o_rd_data next cycle
//   o_rd_data      registered RAM read data
//   o_head_last    head word is a last (10) word; valid combinationally
//   o_empty        no words stored
//   o_eop_cnt      number of complete packets stored
//   o_drop_cnt     packets refused at admission, saturating
module pkt_sync_fifo
  import pkt_merge_arb_pkg::*;
#(
  parameter int unsigned FIFO_AW       = DEF_FIFO_AW,
  parameter int unsigned MAX_PKT_WORDS = DEF_MAX_PKT_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  i_wr_data,
  input  logic               i_wr,
  input  logic               i_rd,
  output logic [WORD_W-1:0]  o_rd_data,
  output logic               o_head_last,
  output logic               o_empty,
  output logic [FIFO_AW:0]   o_eop_cnt,
  output logic [31:0]        o_drop_cnt
);

  localparam int unsigned      DEPTH   = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_W = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] ONE_W   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0] MAX_W   = (FIFO_AW+1)'(MAX_PKT_WORDS);

  logic [WORD_W-1:0]  r_mem     [DEPTH];
  // Copy of each word's tag with an asynchronous read so the arbiter can see
  // a last word at the head in the same cycle it issues the read.
  logic [1:0]         r_tag_mem [DEPTH];
  logic [FIFO_AW:0]   r_wr_ptr;
  logic [FIFO_AW:0]   r_rd_ptr;
  logic [FIFO_AW:0]   r_eop_cnt;
  logic               r_open;     // a packet is in progress on this port
  logic               r_keep;     // the packet in progress was admitted
  logic [31:0]        r_drop_cnt;
  logic [WORD_W-1:0]  r_rd_data;

  logic [FIFO_AW-1:0] w_wr_addr;
  logic [FIFO_AW-1:0] w_rd_addr;
  logic [FIFO_AW:0]   w_used;
  logic [FIFO_AW:0]   w_free;
  logic [1:0]         w_tag;
  logic               w_full;
  logic               w_empty;
  logic               w_admit;
  logic               w_push;
  logic               w_pop;
  logic               w_head_last;
  logic               w_eop_inc;
  logic               w_eop_dec;

  assign w_wr_addr   = r_wr_ptr[FIFO_AW-1:0];
  assign w_rd_addr   = r_rd_ptr[FIFO_AW-1:0];
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) && (w_wr_addr == w_rd_addr);
  assign w_used      = r_wr_ptr - r_rd_ptr;
  assign w_free      = DEPTH_W - w_used;
  assign w_tag       = word_tag(i_wr_data);
  // Admission reserves room for a worst-case packet, so an admitted packet
  // never meets a full FIFO.
  assign w_admit     = (w_free >= MAX_W);
  assign w_pop       = i_rd && !w_empty;
  assign w_head_last = !w_empty && (r_tag_mem[w_rd_addr] == TAG_LAST);
  assign w_eop_inc   = w_push && (w_tag == TAG_LAST);
  assign w_eop_dec   = w_pop && w_head_last;

  // A first word opens a new packet even if one is already open; the old
  // packet's stored words stay and its tail is absorbed into the new one.
  always_comb begin
    w_push = 1'b0;
    if (i_wr && !w_full) begin
      if (w_tag == TAG_FIRST) begin
        w_push = w_admit;
      end else if (w_tag == TAG_MID || w_tag == TAG_LAST) begin
        w_push = r_open && r_keep;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_open     <= 1'b0;
      r_keep     <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_wr) begin
      if (w_tag == TAG_FIRST) begin
        r_open <= 1'b1;
        r_keep <= w_admit;
        if (!w_admit && (r_drop_cnt != 32'hFFFF_FFFF)) begin
          r_drop_cnt <= r_drop_cnt + 32'd1;
        end
      end else if (w_tag == TAG_LAST) begin
        r_open <= 1'b0;
        r_keep <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_eop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ONE_W;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ONE_W;
      case ({w_eop_inc, w_eop_dec})
        2'b10:   r_eop_cnt <= r_eop_cnt + ONE_W;
        2'b01:   r_eop_cnt <= r_eop_cnt - ONE_W;
        default: r_eop_cnt <= r_eop_cnt;
      endcase
    end
  end

  // Storage has no reset; validity is carried by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_addr]     <= i_wr_data;
      r_tag_mem[w_wr_addr] <= w_tag;
    end
    if (w_pop) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  assign o_rd_data   = r_rd_data;
  assign o_head_last = w_head_last;
  assign o_empty     = w_empty;
  assign o_eop_cnt   = r_eop_cnt;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: rtl/pkt_merge_arb.sv
// pkt_merge_arb
//   Merges two packet streams into one. Each port buffers whole packets in a
//   pkt_sync_fifo; an arbiter starts a packet only when one is fully stored
//   and downstream is not almost-full, then streams it out without gaps.
//   Ports alternate round-robin when both have packets waiting.
//
//   Stream handshake: a word is transferred in every cycle its *_wr is high;
//   there is no ready/backpressure. pktout_alf only stops the start of the
//   next packet, never a packet already being sent.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   pktin0_data/pktin0_data_wr  port-0 stream in
//   pktin1_data/pktin1_data_wr  port-1 stream in
//   pktout_alf                  downstream almost-full
//   pktout_data/pktout_data_wr  merged stream out (registered; data 0 when idle)
//   drop_cnt0, drop_cnt1        per-port packets refused at admission
//   o_dbg_state                 arbiter state (arb_state_e encoding)
module pkt_merge_arb
  import pkt_merge_arb_pkg::*;
#(
  parameter int unsigned FIFO_AW       = DEF_FIFO_AW,
  parameter int unsigned MAX_PKT_WORDS = DEF_MAX_PKT_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] pktin0_data,
  input  logic              pktin0_data_wr,
  input  logic [WORD_W-1:0] pktin1_data,
  input  logic              pktin1_data_wr,
  input  logic              pktout_alf,
  output logic [WORD_W-1:0] pktout_data,
  output logic              pktout_data_wr,
  output logic [31:0]       drop_cnt0,
  output logic [31:0]       drop_cnt1,
  output logic [1:0]        o_dbg_state
);

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic              r_grant;    // port being sent
  logic              r_rr;       // port that wins when both are ready
  logic              r_rd_vld;   // a FIFO read was issued last cycle
  logic              r_rd_port;  // which FIFO that read came from
  logic [WORD_W-1:0] r_out_data;
  logic              r_out_wr;

  logic [WORD_W-1:0] w_rd_data0, w_rd_data1;
  logic              w_last0, w_last1;
  logic              w_empty0, w_empty1;
  logic [FIFO_AW:0]  w_eop0, w_eop1;
  logic              w_rdy0, w_rdy1;
  logic              w_pick;
  logic              w_g_last;
  logic              w_rd0, w_rd1;

  pkt_sync_fifo #(.FIFO_AW(FIFO_AW), .MAX_PKT_WORDS(MAX_PKT_WORDS)) u_fifo0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_data   (pktin0_data),
    .i_wr        (pktin0_data_wr),
    .i_rd        (w_rd0),
    .o_rd_data   (w_rd_data0),
    .o_head_last (w_last0),
    .o_empty     (w_empty0),
    .o_eop_cnt   (w_eop0),
    .o_drop_cnt  (drop_cnt0)
  );

  pkt_sync_fifo #(.FIFO_AW(FIFO_AW), .MAX_PKT_WORDS(MAX_PKT_WORDS)) u_fifo1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_data   (pktin1_data),
    .i_wr        (pktin1_data_wr),
    .i_rd        (w_rd1),
    .o_rd_data   (w_rd_data1),
    .o_head_last (w_last1),
    .o_empty     (w_empty1),
    .o_eop_cnt   (w_eop1),
    .o_drop_cnt  (drop_cnt1)
  );

  assign w_rdy0   = (w_eop0 != '0);
  assign w_rdy1   = (w_eop1 != '0);
  // Pointer only matters when both ports are ready.
  assign w_pick   = (w_rdy0 && w_rdy1) ? r_rr : w_rdy1;
  assign w_g_last = r_grant ? w_last1 : w_last0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (!pktout_alf && (w_rdy0 || w_rdy1)) w_next = ST_SEL;
      ST_SEL:  w_next = ST_SEND;
      ST_SEND: if (w_g_last) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output logic: FIFO read enables
  always_comb begin
    w_rd0 = 1'b0;
    w_rd1 = 1'b0;
    if (r_state == ST_SEND) begin
      if (r_grant) w_rd1 = !w_empty1;
      else         w_rd0 = !w_empty0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      if (r_state == ST_SEL) r_grant <= w_pick;
      if (r_state == ST_SEND && w_g_last) r_rr <= ~r_grant;
    end
  end

  // Read-data pipeline: RAM read register, then output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld   <= 1'b0;
      r_rd_port  <= 1'b0;
      r_out_data <= '0;
      r_out_wr   <= 1'b0;
    end else begin
      r_rd_vld   <= w_rd0 || w_rd1;
      r_rd_port  <= w_rd1;
      r_out_wr   <= r_rd_vld;
      r_out_data <= r_rd_vld ? (r_rd_port ? w_rd_data1 : w_rd_data0) : '0;
    end
  end

  assign pktout_data    = r_out_data;
  assign pktout_data_wr = r_out_wr;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_pkt_merge_arb.sv
module tb_pkt_merge_arb;
  import pkt_merge_arb_pkg::*;

  localparam int AW    = 8;
  localparam int MAXW  = 128;
  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [133:0] pktin0_data = '0, pktin1_data = '0;
  logic         pktin0_data_wr = 1'b0, pktin1_data_wr = 1'b0;
  logic         pktout_alf = 1'b0;
  logic [133:0] pktout_data;
  logic         pktout_data_wr;
  logic [31:0]  drop_cnt0, drop_cnt1;
  logic [1:0]   o_dbg_state;

  pkt_merge_arb #(.FIFO_AW(AW), .MAX_PKT_WORDS(MAXW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pktin0_data    (pktin0_data),
    .pktin0_data_wr (pktin0_data_wr),
    .pktin1_data    (pktin1_data),
    .pktin1_data_wr (pktin1_data_wr),
    .pktout_alf     (pktout_alf),
    .pktout_data    (pktout_data),
    .pktout_data_wr (pktout_data_wr),
    .drop_cnt0      (drop_cnt0),
    .drop_cnt1      (drop_cnt1),
    .o_dbg_state    (o_dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- output monitor ----------------
  logic [133:0] got_q[$];
  int   gap_err = 0, zero_err = 0, lat_err = 0;
  logic in_pkt = 1'b0;
  int   send_cyc = 0;
  logic [1:0] prev_st = 2'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_pkt  <= 1'b0;
      prev_st <= ST_IDLE;
    end else begin
      prev_st <= o_dbg_state;
      if (o_dbg_state == ST_SEND && prev_st != ST_SEND) send_cyc <= cyc;
      if (pktout_data_wr) begin
        got_q.push_back(pktout_data);
        if (pktout_data[133:132] == TAG_FIRST) begin
          if (cyc - send_cyc != 2) lat_err <= lat_err + 1;
          in_pkt <= 1'b1;
        end
        if (pktout_data[133:132] == TAG_LAST) in_pkt <= 1'b0;
      end else begin
        if (in_pkt) gap_err <= gap_err + 1;
        if (pktout_data != '0) zero_err <= zero_err + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  // Per-port queues of admitted packets; expected output built by replaying
  // the round-robin rule over whole packets.
  logic [133:0] mw0[$], mw1[$];
  int           ml0[$], ml1[$];
  int           stored[2];
  int           exp_drop[2];
  logic         model_rr = 1'b0;
  logic [133:0] exp_q[$];
  int           first_len;
  int           pkt_id = 0;

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [133:0] mk_word(input logic [1:0] tag, input int port,
                                           input int id, input int idx);
    return {tag, 4'(port), 16'(id), 16'(idx), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_word(input int port, input logic [133:0] w);
    @(negedge clk);
    pktin0_data_wr = 1'b0; pktin1_data_wr = 1'b0;
    pktin0_data = '0; pktin1_data = '0;
    if (port == 0) begin pktin0_data = w; pktin0_data_wr = 1'b1; end
    else           begin pktin1_data = w; pktin1_data_wr = 1'b1; end
  endtask

  task automatic drive_idle();
    @(negedge clk);
    pktin0_data_wr = 1'b0; pktin1_data_wr = 1'b0;
    pktin0_data = '0; pktin1_data = '0;
  endtask

  task automatic drive_pkt(input int port, input int len);
    logic [133:0] w;
    logic [1:0]   tag;
    logic         acc;
    acc = (DEPTH - stored[port]) >= MAXW;
    if (!acc) exp_drop[port]++;
    pkt_id++;
    for (int i = 0; i < len; i++) begin
      tag = (i == 0) ? TAG_FIRST : ((i == len - 1) ? TAG_LAST : TAG_MID);
      w = mk_word(tag, port, pkt_id, i);
      drive_word(port, w);
      if (acc) begin
        if (port == 0) mw0.push_back(w); else mw1.push_back(w);
      end
    end
    if (acc) begin
      stored[port] += len;
      if (port == 0) ml0.push_back(len); else ml1.push_back(len);
    end
    drive_idle();
  endtask

  task automatic drive_orphans(input int port);
    drive_word(port, mk_word(TAG_MID, port, 0, 0));
    drive_word(port, mk_word(TAG_LAST, port, 0, 1));
    drive_idle();
  endtask

  task automatic build_exp();
    logic pick;
    int   len;
    first_len = -1;
    while (ml0.size() > 0 || ml1.size() > 0) begin
      if (ml0.size() > 0 && ml1.size() > 0) pick = model_rr;
      else pick = (ml1.size() > 0);
      if (pick == 1'b0) begin
        len = ml0.pop_front();
        repeat (len) exp_q.push_back(mw0.pop_front());
      end else begin
        len = ml1.pop_front();
        repeat (len) exp_q.push_back(mw1.pop_front());
      end
      if (first_len < 0) first_len = len;
      model_rr = ~pick;
    end
    stored[0] = 0;
    stored[1] = 0;
  endtask

  task automatic check_out(input string tag);
    int t;
    int n;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    chk_int({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_word"}, got_q[i], exp_q[i]);
    chk_int({tag, "_gaps"}, gap_err, 0);
    chk_int({tag, "_idle_zero"}, zero_err, 0);
    chk_int({tag, "_latency"}, lat_err, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int t;
    stored[0] = 0; stored[1] = 0;
    exp_drop[0] = 0; exp_drop[1] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_wr", {133'd0, pktout_data_wr}, 134'd0);
    chk("reset_data", pktout_data, 134'd0);
    chk_int("reset_drop0", int'(drop_cnt0), 0);
    chk_int("reset_drop1", int'(drop_cnt1), 0);
    chk_int("reset_state", int'(o_dbg_state), int'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 4-word packet on port 1
    drive_pkt(1, 4);
    build_exp();
    check_out("single_p1");

    // One 3-word packet on each port, released together
    pktout_alf = 1'b1;
    drive_pkt(0, 3);
    drive_pkt(1, 3);
    pktout_alf = 1'b0;
    build_exp();
    check_out("both_3w");

    // Orphan words on port 1 while idle
    drive_orphans(1);
    drive_orphans(1);
    repeat (20) @(negedge clk);
    chk_int("orphan_no_out", got_q.size(), 0);
    chk_int("orphan_drop1", int'(drop_cnt1), exp_drop[1]);

    // Almost-full raised one word into an 8-word packet
    pktout_alf = 1'b1;
    drive_pkt(0, 8);
    drive_pkt(1, 3);
    build_exp();
    pktout_alf = 1'b0;
    t = 0;
    while (got_q.size() < 1 && t < 200) begin @(negedge clk); t++; end
    pktout_alf = 1'b1;
    repeat (40) @(negedge clk);
    chk_int("alf_mid_only_first", got_q.size(), first_len);
    pktout_alf = 1'b0;
    check_out("alf_mid");

    // Admission drop: 130 words held on port 0, then a new packet arrives
    pktout_alf = 1'b1;
    drive_pkt(0, 65);
    drive_pkt(0, 65);
    drive_pkt(0, 10);
    drive_pkt(1, 4);
    chk_int("drop0_after_full", int'(drop_cnt0), exp_drop[0]);
    chk_int("drop0_is_one", int'(drop_cnt0), 1);
    pktout_alf = 1'b0;
    build_exp();
    check_out("admission");

    // Random rounds: packets loaded behind almost-full, then drained
    for (int r = 0; r < 5; r++) begin
      int np;
      pktout_alf = 1'b1;
      np = $urandom_range(2, 7);
      for (int k = 0; k < np; k++) begin
        if ($urandom_range(0, 3) == 0) drive_orphans($urandom_range(0, 1));
        drive_pkt($urandom_range(0, 1), $urandom_range(2, 48));
      end
      chk_int("rand_drop0", int'(drop_cnt0), exp_drop[0]);
      chk_int("rand_drop1", int'(drop_cnt1), exp_drop[1]);
      pktout_alf = 1'b0;
      build_exp();
      check_out("rand");
    end

    // Reset pulsed while a packet is being sent
    pktout_alf = 1'b1;
    drive_pkt(1, 8);
    pktout_alf = 1'b0;
    t = 0;
    while (got_q.size() < 2 && t < 200) begin @(negedge clk); t++; end
    #2 rst_n = 1'b0;
    #1 chk("rst_async_wr", {133'd0, pktout_data_wr}, 134'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mw0.delete(); mw1.delete(); ml0.delete(); ml1.delete();
    stored[0] = 0; stored[1] = 0;
    exp_drop[0] = 0; exp_drop[1] = 0;
    model_rr = 1'b0;
    got_q.delete();
    exp_q.delete();
    repeat (40) @(negedge clk);
    chk_int("rst_no_output", got_q.size(), 0);
    chk_int("rst_drop0", int'(drop_cnt0), 0);
    drive_pkt(0, 5);
    build_exp();
    check_out("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pkt_merge_arb.md
PKT_MERGE_ARB -- requirements
Module: pkt_merge_arb

Interface
REQ-001 Parameter FIFO_AW, 8, per-port FIFO address width (depth 2^FIFO_AW words).
REQ-002 Parameter MAX_PKT_WORDS, 128, worst-case packet length in 134-bit words, used for admission.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pktin0_data  input  134  port-0 stream; [133:132] 01=first, 11=middle, 10=last word.
REQ-006 pktin0_data_wr  input  1  port-0 word valid; no backpressure to source.
REQ-007 pktin1_data  input  134  port-1 stream (encapsulator output), same format.
REQ-008 pktin1_data_wr  input  1  port-1 word valid.
REQ-009 pktout_alf  input  1  downstream almost-full; blocks start of a new packet only.
REQ-010 pktout_data  output  134  merged stream.
REQ-011 pktout_data_wr  output  1  merged word valid.
REQ-012 drop_cnt0, drop_cnt1  output  32 each  packets dropped at admission per port, saturating at 2^32-1.

Function
REQ-013 Each port SHALL own a data FIFO of 2^FIFO_AW x 134 and an EOP counter (FIFO_AW+1 bits) of complete packets stored.
REQ-014 Admission: on a first word (01, wr=1), packet SHALL be accepted iff free words >= MAX_PKT_WORDS, else all words through its last word SHALL be discarded and drop_cntN incremented once.
REQ-015 Words with wr=1 arriving outside a packet and not marked 01 (orphans) SHALL be discarded without counting.
REQ-016 A 01 word arriving while a packet is open on that port SHALL close the open packet by rewriting nothing; the new packet SHALL be admitted per REQ-014 and the open packet's remaining words treated as the new packet's (no error recovery beyond this).
REQ-017 EOP counter SHALL +1 when a 10 word is written, -1 when a 10 word is read, unchanged when both in the same cycle.
REQ-018 Arbiter FSM states: IDLE, SEL, SEND.
REQ-019 IDLE->SEL when pktout_alf=0 and any EOP counter>0; otherwise stay IDLE.
REQ-020 SEL: grant by round-robin, port with pointer priority first; pointer initial value port 0, toggled to the other port after each granted packet's last word; if only one port ready it SHALL be granted regardless of pointer.
REQ-021 SEND: read granted FIFO one word per cycle, no bubbles; pktout_alf SHALL be ignored mid-packet; on reading a 10 word return to IDLE.
REQ-022 pktout_data/pktout_data_wr SHALL be registered; latency from FIFO read enable to output = 2 cycles (1 RAM read + 1 output register).
REQ-023 pktout_data_wr SHALL be 1 exactly for each word of a granted packet and 0 otherwise; pktout_data SHALL be 0 when wr=0.
REQ-024 Output packets SHALL never interleave; word order within a packet SHALL be preserved.
REQ-025 Simultaneous write and read of the same FIFO SHALL be supported in one cycle.
REQ-026 Pointers SHALL wrap modulo 2^FIFO_AW; full/empty by extra MSB comparison.

Reset
REQ-027 On rst_n=0: FSM=IDLE, RR pointer=port 0, all FIFO pointers, EOP counters, admission flags, drop counters, pktout_data, pktout_data_wr = 0.
REQ-028 Reset mid-packet SHALL discard all stored and in-flight words; no partial packet SHALL be emitted after release.

Structure
REQ-029 Shared package SHALL hold word-type constants (01/11/10), FSM state encodings, and default parameter values.
REQ-030 One sub-module pkt_sync_fifo (data RAM, wr/rd pointers, free-word count, EOP counter) SHALL be instantiated twice.
REQ-031 Arbiter FSM, RR pointer and output register SHALL live in pkt_merge_arb.

Verification
REQ-032 Single 4-word packet on port 1, idle port 0 -> same 4 words on output, wr high 4 consecutive cycles, first word 2 cycles after grant.
REQ-033 Both ports hold one 3-word packet at reset release -> port 0 packet then port 1 packet, no interleave, 6 output words.
REQ-034 FIFO_AW=8, MAX_PKT_WORDS=128, port 0 holds 130 words, pktout_alf=1, new packet arrives -> dropped, drop_cnt0=1, later output contains only stored packets.
REQ-035 pktout_alf asserted 1 cycle into an 8-word packet -> all 8 words still emitted contiguously; next packet waits until alf=0.
REQ-036 Orphan 11/10 words on port 1 in idle -> no output, drop_cnt1 unchanged.
REQ-037 rst_n pulsed low mid-SEND -> wr drops to 0 asynchronously, no output after release until new complete packet arrives.
